// File: rtl/m68k_bus_pkg.sv
// m68k_bus_pkg
//   Shared definitions for the 68000 bus master: FSM state encoding,
//   data-strobe timing relative to _AS, and a helper that maps byte
//   enables onto the active-low _UDS/_LDS pair.
package m68k_bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_ACK,
      S_ADDR,
      S_STRB,
      S_WAIT,
      S_LATCH,
      S_END
   } state_t;

   // Reads drop the data strobes together with _AS; writes hold them off
   // one cycle so the data bus is settled before the slave sees them.
   localparam logic RD_DS_WITH_AS = 1'b1;
   localparam logic WR_DS_WITH_AS = 1'b0;

   // {_UDS, _LDS} for a given byte-enable pair (be[1] = upper byte).
   function automatic logic [1:0] ds_n(input logic [1:0] be);
      return ~be;
   endfunction

endpackage

// File: rtl/sync2.sv
// sync2
//   Two-flop synchroniser for one asynchronous, active-low bus status
//   line. Both flops reset to 1 (inactive) so nothing looks asserted
//   while the block comes out of reset.
//   Ports: clk, rst (async active-high), d (async in), q (synchronised).
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/m68k_bus_master.sv
// m68k_bus_master
//   Takes a one-cycle transfer request, arbitrates for the 68000 bus
//   (_BR/_BG/_BGACK), runs one read or write bus cycle and reports done,
//   or err on bus error, timeout or empty byte enables.
//   User side : req, rnw, addr, be, wdata -> busy, done, err, rdata.
//   Bus side  : _BR, _BGACK, _AS, _UDS, _LDS, R_W, A, A_OE, D_OUT, D_OE out;
//               _BG, _DTACK, _BERR, _AS_IN, D_IN in (status lines resynced).
//   Parameters: TIMEOUT (cycles to wait for _DTACK/_BERR), HOLD_BUS (keep
//               bus ownership for a request arriving in the END cycle).
module m68k_bus_master
   import m68k_bus_pkg::*;
#(
   parameter int TIMEOUT  = 64,
   parameter int HOLD_BUS = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        req,
   input  logic        rnw,
   input  logic [22:0] addr,
   input  logic [1:0]  be,
   input  logic [15:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] rdata,
   output logic        _BR,
   input  logic        _BG,
   output logic        _BGACK,
   output logic        _AS,
   output logic        _UDS,
   output logic        _LDS,
   output logic        R_W,
   output logic [22:0] A,
   output logic        A_OE,
   output logic [15:0] D_OUT,
   output logic        D_OE,
   input  logic [15:0] D_IN,
   input  logic        _DTACK,
   input  logic        _BERR,
   input  logic        _AS_IN
);

   localparam int               CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   logic bg_s, dtack_s, berr_s, as_s;

   sync2 u_sync_bg    (.clk(CLK), .rst(RESET), .d(_BG),    .q(bg_s));
   sync2 u_sync_dtack (.clk(CLK), .rst(RESET), .d(_DTACK), .q(dtack_s));
   sync2 u_sync_berr  (.clk(CLK), .rst(RESET), .d(_BERR),  .q(berr_s));
   sync2 u_sync_as    (.clk(CLK), .rst(RESET), .d(_AS_IN), .q(as_s));

   state_t            state_q, state_d;
   logic              rnw_q, rnw_d;
   logic [22:0]       addr_q, addr_d;
   logic [1:0]        be_q, be_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [15:0]       rdata_q, rdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              br_n_q, br_n_d;
   logic              bgack_n_q, bgack_n_d;
   logic              as_n_q, as_n_d;
   logic              uds_n_q, uds_n_d;
   logic              lds_n_q, lds_n_d;
   logic              a_oe_q, a_oe_d;
   logic              d_oe_q, d_oe_d;

   logic              load;
   logic              abort;
   logic [CNT_W-1:0]  cnt_inc;

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   // _BERR wins over _DTACK; the timeout only fires if no acknowledge came.
   assign abort   = !berr_s || (dtack_s && (cnt_inc == CNT_MAX));

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      rdata_d   = rdata_q;
      cnt_d     = cnt_q;
      br_n_d    = br_n_q;
      bgack_n_d = bgack_n_q;
      as_n_d    = as_n_q;
      uds_n_d   = uds_n_q;
      lds_n_d   = lds_n_q;
      a_oe_d    = a_oe_q;
      d_oe_d    = d_oe_q;
      load      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               if (be == 2'b00) begin
                  err_d = 1'b1;
               end else begin
                  load    = 1'b1;
                  busy_d  = 1'b1;
                  br_n_d  = 1'b0;
                  state_d = S_ARB;
               end
            end
         end
         S_ARB: begin
            // Granted and the previous master has released _AS.
            if (!bg_s && as_s) begin
               bgack_n_d = 1'b0;
               br_n_d    = 1'b1;
               state_d   = S_ACK;
            end
         end
         S_ACK: begin
            a_oe_d  = 1'b1;
            d_oe_d  = !rnw_q;
            state_d = S_ADDR;
         end
         S_ADDR: begin
            as_n_d = 1'b0;
            if (rnw_q ? RD_DS_WITH_AS : WR_DS_WITH_AS)
               {uds_n_d, lds_n_d} = ds_n(be_q);
            state_d = S_STRB;
         end
         S_STRB: begin
            {uds_n_d, lds_n_d} = ds_n(be_q);
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_inc;
            if (abort) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               as_n_d  = 1'b1;
               uds_n_d = 1'b1;
               lds_n_d = 1'b1;
               state_d = S_END;
            end else if (!dtack_s) begin
               state_d = S_LATCH;
            end
         end
         S_LATCH: begin
            if (rnw_q)
               rdata_d = D_IN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            as_n_d  = 1'b1;
            uds_n_d = 1'b1;
            lds_n_d = 1'b1;
            state_d = S_END;
         end
         S_END: begin
            if ((HOLD_BUS != 0) && req && (be != 2'b00)) begin
               load    = 1'b1;
               busy_d  = 1'b1;
               d_oe_d  = !rnw;
               state_d = S_ADDR;
            end else begin
               // Drivers drop here, one cycle after the strobes went high.
               a_oe_d    = 1'b0;
               d_oe_d    = 1'b0;
               bgack_n_d = 1'b1;
               state_d   = S_IDLE;
               if (req && (be == 2'b00))
                  err_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rnw_d   = load ? rnw   : rnw_q;
   assign addr_d  = load ? addr  : addr_q;
   assign be_d    = load ? be    : be_q;
   assign wdata_d = load ? wdata : wdata_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         rnw_q     <= 1'b1;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         cnt_q     <= '0;
         br_n_q    <= 1'b1;
         bgack_n_q <= 1'b1;
         as_n_q    <= 1'b1;
         uds_n_q   <= 1'b1;
         lds_n_q   <= 1'b1;
         a_oe_q    <= 1'b0;
         d_oe_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rnw_q     <= rnw_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         cnt_q     <= cnt_d;
         br_n_q    <= br_n_d;
         bgack_n_q <= bgack_n_d;
         as_n_q    <= as_n_d;
         uds_n_q   <= uds_n_d;
         lds_n_q   <= lds_n_d;
         a_oe_q    <= a_oe_d;
         d_oe_q    <= d_oe_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign rdata  = rdata_q;
   assign _BR    = br_n_q;
   assign _BGACK = bgack_n_q;
   assign _AS    = as_n_q;
   assign _UDS   = uds_n_q;
   assign _LDS   = lds_n_q;
   assign R_W    = rnw_q;
   assign A      = addr_q;
   assign A_OE   = a_oe_q;
   assign D_OUT  = wdata_q;
   assign D_OE   = d_oe_q;

endmodule

// File: tb/tb_m68k_bus_master.sv
module tb_m68k_bus_master;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        req = 1'b0;
   logic        rnw = 1'b1;
   logic [22:0] addr = '0;
   logic [1:0]  be = '0;
   logic [15:0] wdata = '0;
   logic        busy, done, err;
   logic [15:0] rdata;
   logic        br_n, bgack_n, as_n, uds_n, lds_n, r_w, a_oe, d_oe;
   logic [22:0] a;
   logic [15:0] d_out;
   logic        bg_n = 1'b1;
   logic        dtack_n = 1'b1;
   logic        berr_n = 1'b1;
   logic [15:0] d_in = '0;

   always #5 CLK = ~CLK;

   m68k_bus_master #(.TIMEOUT(64), .HOLD_BUS(1)) dut (
      .CLK(CLK), .RESET(RESET), .req(req), .rnw(rnw), .addr(addr), .be(be),
      .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
      ._BR(br_n), ._BG(bg_n), ._BGACK(bgack_n), ._AS(as_n), ._UDS(uds_n),
      ._LDS(lds_n), .R_W(r_w), .A(a), .A_OE(a_oe), .D_OUT(d_out), .D_OE(d_oe),
      .D_IN(d_in), ._DTACK(dtack_n), ._BERR(berr_n), ._AS_IN(as_n)
   );

   // Arbiter: grant follows request one cycle later.
   always @(negedge CLK) bg_n = br_n;

   // Slave: responds slv_delay cycles after first seeing _AS low.
   int          slv_delay = 0;
   logic        slv_ack = 1'b0;
   logic        slv_berr = 1'b0;
   logic [15:0] slv_din = '0;
   int          slv_cnt = 0;

   always @(negedge CLK) begin
      if (as_n == 1'b0) begin
         if (slv_cnt == slv_delay) begin
            dtack_n = ~slv_ack;
            berr_n  = ~slv_berr;
            d_in    = slv_din;
         end
         slv_cnt = slv_cnt + 1;
      end else begin
         slv_cnt = 0;
         dtack_n = 1'b1;
         berr_n  = 1'b1;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rnw;
      logic [22:0] addr;
      logic [1:0]  be;
      logic [15:0] wdata;
      int          delay;
      logic        ack;
      logic        berr;
      logic [15:0] din;
      logic        exp_done;
      logic        exp_err;
      logic [15:0] exp_rdata;
      int          exp_uds;   // cycles from _AS low to _UDS low, -1 = never
      int          exp_lds;
      int          exp_lat;   // cycles from _AS low to done/err, -1 = unchecked
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input vec_t v, input string tag);
      int cyc, as_cyc, uds_cyc, lds_cyc, end_cyc;
      logic [22:0] a_seen;
      logic rw_seen, doe_seen, done_seen, err_seen, as_end, ds_end, aoe_end;
      logic [15:0] dout_seen, rdata_seen;
      slv_delay = v.delay; slv_ack = v.ack; slv_berr = v.berr; slv_din = v.din;
      @(negedge CLK);
      req = 1'b1; rnw = v.rnw; addr = v.addr; be = v.be; wdata = v.wdata;
      @(negedge CLK);
      req = 1'b0;
      cyc = 0; as_cyc = -1; uds_cyc = -1; lds_cyc = -1; end_cyc = -1;
      a_seen = 'x; rw_seen = 'x; doe_seen = 'x; dout_seen = 'x;
      done_seen = 'x; err_seen = 'x; rdata_seen = 'x; as_end = 'x; ds_end = 'x; aoe_end = 'x;
      while (end_cyc < 0 && cyc < 300) begin
         if (as_n == 1'b0 && as_cyc < 0) begin
            as_cyc = cyc; a_seen = a; rw_seen = r_w; doe_seen = d_oe; dout_seen = d_out;
         end
         if (uds_n == 1'b0 && uds_cyc < 0) uds_cyc = cyc;
         if (lds_n == 1'b0 && lds_cyc < 0) lds_cyc = cyc;
         if (done || err) begin
            end_cyc = cyc; done_seen = done; err_seen = err; rdata_seen = rdata;
            as_end = as_n; ds_end = uds_n & lds_n; aoe_end = a_oe;
         end else begin
            @(negedge CLK);
            cyc++;
         end
      end
      chk({tag, "_finished"}, end_cyc >= 0, 1);
      chk({tag, "_done"}, done_seen, v.exp_done);
      chk({tag, "_err"}, err_seen, v.exp_err);
      chk({tag, "_rdata"}, rdata_seen, v.exp_rdata);
      chk({tag, "_addr"}, a_seen, v.addr);
      chk({tag, "_rw"}, rw_seen, v.rnw);
      chk({tag, "_doe"}, doe_seen, !v.rnw);
      if (!v.rnw) chk({tag, "_dout"}, dout_seen, v.wdata);
      chk({tag, "_uds_lag"}, (uds_cyc < 0) ? -1 : uds_cyc - as_cyc, v.exp_uds);
      chk({tag, "_lds_lag"}, (lds_cyc < 0) ? -1 : lds_cyc - as_cyc, v.exp_lds);
      chk({tag, "_strobes_off_at_end"}, {as_end, ds_end, aoe_end}, 3'b111);
      if (v.exp_lat >= 0) chk({tag, "_latency"}, end_cyc - as_cyc, v.exp_lat);
      @(negedge CLK);
      chk({tag, "_pulse_one_cycle"}, {done, err}, 2'b00);
      chk({tag, "_released"}, {bgack_n, a_oe, d_oe, busy, as_n}, 5'b10001);
   endtask

   initial begin
      logic hold_ok, pulse_seen;
      int cyc;

      // Reset state
      repeat (3) @(negedge CLK);
      chk("rst_active_low_outs", {br_n, bgack_n, as_n, uds_n, lds_n}, 5'b11111);
      chk("rst_enables_flags", {a_oe, d_oe, busy, done, err}, 5'b00000);
      chk("rst_rdata", rdata, 16'h0000);
      RESET = 1'b0;
      repeat (2) @(negedge CLK);

      //            rnw  addr        be     wdata     dly ack berr din       done err rdata    uds lds lat
      vecs[0] = '{1'b1, 23'h3E0000, 2'b11, 16'h0000, 3, 1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0, 16'hBEEF,  0,  0,  7};
      vecs[1] = '{1'b0, 23'h000010, 2'b01, 16'h00A5, 2, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hBEEF, -1,  1, -1};
      vecs[2] = '{1'b0, 23'h155555, 2'b10, 16'h5A00, 1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hBEEF,  1, -1, -1};
      vecs[3] = '{1'b1, 23'h000123, 2'b10, 16'h0000, 0, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h1234,  0, -1,  4};
      vecs[4] = '{1'b1, 23'h2AAAAA, 2'b11, 16'h0000, 2, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 16'h1234,  0,  0,  5};
      vecs[5] = '{1'b0, 23'h000002, 2'b11, 16'h0F0F, 1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h1234,  1,  1, -1};
      vecs[6] = '{1'b1, 23'h7FFFFF, 2'b01, 16'h0000, 5, 1'b1, 1'b0, 16'h00C3, 1'b1, 1'b0, 16'h00C3, -1,  0,  9};
      vecs[7] = '{1'b1, 23'h000040, 2'b11, 16'h0000, 0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h00C3,  0,  0, 65};

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Empty byte enables: err next cycle, no bus activity.
      @(negedge CLK);
      req = 1'b1; rnw = 1'b1; be = 2'b00; addr = 23'h000100;
      @(negedge CLK);
      req = 1'b0;
      chk("be00_err", err, 1'b1);
      chk("be00_no_busy_no_br", {busy, br_n}, 2'b01);
      @(negedge CLK);
      chk("be00_err_one_cycle", err, 1'b0);
      chk("be00_still_idle", {busy, br_n, a_oe}, 3'b010);

      // Back-to-back: second request lands in the END cycle of the first.
      slv_delay = 1; slv_ack = 1'b1; slv_berr = 1'b0; slv_din = 16'h0000;
      @(negedge CLK);
      req = 1'b1; rnw = 1'b0; be = 2'b11; addr = 23'h000200; wdata = 16'h1357;
      @(negedge CLK);
      req = 1'b0;
      cyc = 0;
      while (!(done || err) && cyc < 300) begin @(negedge CLK); cyc++; end
      chk("b2b_first_done", done, 1'b1);
      req = 1'b1; rnw = 1'b1; be = 2'b11; addr = 23'h000456;
      slv_delay = 2; slv_din = 16'h2468;
      @(negedge CLK);
      req = 1'b0;
      cyc = 0; hold_ok = 1'b1;
      while (!(done || err) && cyc < 300) begin
         if (br_n !== 1'b1 || bgack_n !== 1'b0 || a_oe !== 1'b1) hold_ok = 1'b0;
         @(negedge CLK);
         cyc++;
      end
      chk("b2b_bus_held", hold_ok, 1'b1);
      chk("b2b_second_done", {done, err}, 2'b10);
      chk("b2b_second_rdata", rdata, 16'h2468);
      @(negedge CLK);
      chk("b2b_released", {bgack_n, a_oe}, 2'b10);

      // Reset while waiting for an acknowledge that never comes.
      slv_ack = 1'b0; slv_berr = 1'b0;
      @(negedge CLK);
      req = 1'b1; rnw = 1'b1; be = 2'b11; addr = 23'h000001;
      @(negedge CLK);
      req = 1'b0;
      cyc = 0;
      while (as_n !== 1'b0 && cyc < 100) begin @(negedge CLK); cyc++; end
      chk("rstw_reached_strobe", as_n, 1'b0);
      repeat (4) @(negedge CLK);
      chk("rstw_busy_before", busy, 1'b1);
      RESET = 1'b1;
      #1;
      chk("rstw_active_low_outs", {br_n, bgack_n, as_n, uds_n, lds_n}, 5'b11111);
      chk("rstw_enables_flags", {a_oe, d_oe, busy, done, err}, 5'b00000);
      chk("rstw_rdata", rdata, 16'h0000);
      pulse_seen = 1'b0;
      repeat (3) begin @(negedge CLK); if (done || err) pulse_seen = 1'b1; end
      RESET = 1'b0;
      repeat (6) begin @(negedge CLK); if (done || err) pulse_seen = 1'b1; end
      chk("rstw_no_pulse", pulse_seen, 1'b0);
      chk("rstw_idle_after", {br_n, busy}, 2'b10);
      run_vec('{1'b1, 23'h000ABC, 2'b11, 16'h0000, 2, 1'b1, 1'b0, 16'hCAFE,
                1'b1, 1'b0, 16'hCAFE, 0, 0, 6}, "post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
